btn_event_ctrl: RTL
===================

# btn_event_ctrl

Sequences the debounced button levels from the per-button debouncers into a single ordered stream of button events: press, auto-repeat while held, and release. The block sits between the debouncer bank and the game/UI logic. It runs one hold/repeat state machine per button, arbitrates simultaneous events round-robin, and buffers them in a small FIFO behind a valid/ready handshake. Consumers therefore never deal with levels, hold timing or contention.

## Interface
- `NUM_BTNS`, default 4: number of debounced button inputs, range 2–8.
- `BTN_W`, default 2: width of the button index; must satisfy 2^BTN_W ≥ NUM_BTNS.
- `CNT_W`, default 26: hold/repeat counter width.
- `HOLD_DELAY`, default 50_000_000: cycles from PRESS to first REPEAT; must be ≥ 2.
- `REPEAT_PERIOD`, default 10_000_000: cycles between successive REPEATs; must be ≥ 2.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of 2.
- `clk`  in  1: system clock, single clock domain.
- `reset`  in  1: synchronous, active-high.
- `btn_level`  in  NUM_BTNS: debounced levels (debouncer `btn_pressed` outputs), 1 = pressed.
- `evt_valid`  out  1: FIFO non-empty; reset value 0.
- `evt_ready`  in  1: consumer accepts the head event when `evt_valid` & `evt_ready`.
- `evt_btn`  out  BTN_W: button index of the head event; reset value 0.
- `evt_kind`  out  2: event type of the head event, 0 PRESS, 1 REPEAT, 2 RELEASE; reset value 0.
- `evt_dropped`  out  1: sticky, set when any event is discarded; cleared only by reset; reset value 0.

## Operation
- **Edge detection:** per button, `prev` register. Rise is `btn_level & ~prev`. Fall is `~btn_level & prev`.
- **Per-button FSM (IDLE, WAIT, RPT):**
  - IDLE: rise → emit PRESS, counter cleared, go to WAIT. Fall is ignored.
  - WAIT: counter counts up; reaching HOLD_DELAY-1 → emit REPEAT, counter cleared, go to RPT.
  - RPT: reaching REPEAT_PERIOD-1 → emit REPEAT, counter cleared, stay in RPT.
  - WAIT or RPT: fall → emit RELEASE, go to IDLE. Fall takes precedence over a same-cycle counter expiry.
- **Pending slot:** each button has one slot holding a kind.
  - An emitted event fills an empty slot.
  - It also fills a slot whose content is being granted in the same cycle; nothing is dropped in that case.
  - If the slot is full and not granted: RELEASE replaces a pending REPEAT. Any other new event is discarded. Both cases set `evt_dropped`.
- **Arbiter:**
  - Runs when FIFO count < FIFO_DEPTH, using the registered count. A same-cycle pop does not free space.
  - Grants one pending slot per cycle, searching upward from `rr_ptr` with wrap-around.
  - The granted event is pushed and its slot cleared. Then `rr_ptr` ← granted index + 1, modulo NUM_BTNS.
- **FIFO:** registered read/write pointers and count. `evt_btn`/`evt_kind` show the head entry. Pop occurs on `evt_valid & evt_ready`.
- **Reset:**
  - `prev` ← `btn_level`. A button held through reset produces no PRESS, and its later release produces no RELEASE.
  - All FSMs → IDLE; slots, FIFO, `rr_ptr` and `evt_dropped` cleared.
  - Reset mid-operation discards all queued and pending events.

## Timing
- **Press latency:** `btn_level` first sampled high at edge E0 → slot filled at E0, FIFO written at E1, `evt_valid`=1 in the cycle after E1. That is 2 edges with an empty FIFO and no contention.
- **Repeat timing:** first REPEAT is emitted HOLD_DELAY cycles after the PRESS emission edge. Subsequent REPEATs are emitted every REPEAT_PERIOD cycles.
- **Handshake:** `evt_btn`/`evt_kind` are stable while `evt_valid` & ~`evt_ready`. Throughput is 1 event/cycle.
- **Full FIFO:** no grants occur. Slots hold their events; new events follow the pending-slot rules.
- **Counters:** CNT_W wide, compared for equality against parameter-1, never wrap.

## Structure
- **Shared package (`btn_pkg`):**
  - event-kind constants `EVT_PRESS`/`EVT_REPEAT`/`EVT_RELEASE`
  - FSM state encodings `ST_IDLE`/`ST_WAIT`/`ST_RPT`
- **Sub-module `btn_hold_fsm`:** one per button, via generate. It contains `prev`, the FSM, the counter and the emit strobe/kind.
- **Top level:** the arbiter, pending slots and FIFO stay in the top level.

## Test plan
All scenarios use HOLD_DELAY=8, REPEAT_PERIOD=4, `evt_ready`=1 unless stated.
1. **Press/release:** btn 1 pressed for 5 cycles → PRESS(1) with `evt_valid` 2 edges after the rise, then RELEASE(1). No REPEAT.
2. **Hold:** btn 2 held for 20 cycles → PRESS, REPEAT at +8, +12, +16, then RELEASE. `evt_dropped`=0.
3. **Contention:** buttons 0, 1 and 3 rise in the same cycle with `rr_ptr`=0 → events output on consecutive cycles in order 0, 1, 3. `rr_ptr`=0 afterward.
4. **Backpressure:** `evt_ready`=0, 6 events generated on distinct buttons with FIFO_DEPTH=4 → 4 queued, remaining events held in their slots. After `evt_ready`=1, all 6 are delivered in order and `evt_dropped`=0.
5. **Drop/replace:** `evt_ready`=0, FIFO full, btn 0 holds a pending REPEAT, then btn 0 releases → slot becomes RELEASE and `evt_dropped`=1.
6. **Reset with button held:** btn 2 held through reset, then released → no events, `evt_valid` stays 0. Reset asserted with 3 queued events → `evt_valid`=0 on the next cycle.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the button event controller.
// Event kinds, hold FSM state encodings and the slot replace rule.
package btn_pkg;

   typedef logic [1:0] evt_kind_t;

   localparam evt_kind_t EVT_PRESS   = 2'd0;
   localparam evt_kind_t EVT_REPEAT  = 2'd1;
   localparam evt_kind_t EVT_RELEASE = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RPT  = 2'd2;

   // A release may overwrite a stale pending repeat; nothing else may.
   function automatic logic can_replace(
      input evt_kind_t new_k,
      input evt_kind_t old_k
   );
      return (new_k == EVT_RELEASE) && (old_k == EVT_REPEAT);
   endfunction

endpackage

// File: rtl/btn_hold_fsm.sv
// Per-button edge detector and hold/repeat state machine.
// Emits a one-cycle strobe with the event kind on press, repeat, release.
module btn_hold_fsm
   import btn_pkg::*;
#(
   parameter int CNT_W         = 26,
   parameter int HOLD_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            btn_level,
   output logic            emit,
   output evt_kind_t       emit_kind
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_PERIOD - 1);

   logic             prev_q, prev_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rise, fall;

   // Next-state logic; a release beats a same-cycle counter expiry.
   always_comb begin
      rise      = btn_level & ~prev_q;
      fall      = ~btn_level & prev_q;
      prev_d    = btn_level;
      state_d   = state_q;
      cnt_d     = cnt_q;
      emit      = 1'b0;
      emit_kind = EVT_PRESS;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               emit      = 1'b1;
               emit_kind = EVT_PRESS;
               cnt_d     = '0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (fall) begin
               emit      = 1'b1;
               emit_kind = EVT_RELEASE;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end else if (cnt_q == HOLD_LAST) begin
               emit      = 1'b1;
               emit_kind = EVT_REPEAT;
               cnt_d     = '0;
               state_d   = ST_RPT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RPT: begin
            if (fall) begin
               emit      = 1'b1;
               emit_kind = EVT_RELEASE;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end else if (cnt_q == RPT_LAST) begin
               emit      = 1'b1;
               emit_kind = EVT_REPEAT;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; prev tracks the live level so held buttons stay silent.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q  <= btn_level;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         prev_q  <= prev_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event sequencer: per-button hold FSMs, pending slots,
// round-robin arbiter and an event FIFO behind a valid/ready port.
module btn_event_ctrl
   import btn_pkg::*;
#(
   parameter int NUM_BTNS      = 4,
   parameter int BTN_W         = 2,
   parameter int CNT_W         = 26,
   parameter int HOLD_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_level,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [BTN_W-1:0]    evt_btn,
   output logic [1:0]          evt_kind,
   output logic                evt_dropped
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);
   localparam logic [BTN_W-1:0]  LAST_BTN  = BTN_W'(NUM_BTNS - 1);

   logic [NUM_BTNS-1:0]            emit;
   evt_kind_t [NUM_BTNS-1:0]       emit_kind;

   logic [NUM_BTNS-1:0]            slot_vld_q, slot_vld_d;
   evt_kind_t [NUM_BTNS-1:0]       slot_kind_q, slot_kind_d;
   logic                           dropped_q, dropped_d;

   logic [BTN_W-1:0]               rr_ptr_q, rr_ptr_d;
   logic                           gnt_vld;
   logic [BTN_W-1:0]               gnt_idx;
   logic [NUM_BTNS-1:0]            gnt_oh;

   logic [FIFO_DEPTH-1:0][BTN_W-1:0] mem_btn_q, mem_btn_d;
   evt_kind_t [FIFO_DEPTH-1:0]     mem_kind_q, mem_kind_d;
   logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]              fifo_cnt_q, fifo_cnt_d;
   logic                           push, pop;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      btn_hold_fsm #(
         .CNT_W         (CNT_W),
         .HOLD_DELAY    (HOLD_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_fsm (
         .clk       (clk),
         .reset     (reset),
         .btn_level (btn_level[i]),
         .emit      (emit[i]),
         .emit_kind (emit_kind[i])
      );
   end

   // Round-robin grant of one pending slot, only while the FIFO has room.
   always_comb begin
      logic [BTN_W-1:0] cand;
      cand     = '0;
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      gnt_oh   = '0;
      rr_ptr_d = rr_ptr_q;
      if (fifo_cnt_q < FIFO_FULL) begin
         for (int k = 0; k < NUM_BTNS; k++) begin
            cand = BTN_W'((int'(rr_ptr_q) + k) % NUM_BTNS);
            if (!gnt_vld && slot_vld_q[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      if (gnt_vld) begin
         gnt_oh[gnt_idx] = 1'b1;
         rr_ptr_d = (gnt_idx == LAST_BTN) ? '0 : gnt_idx + BTN_W'(1);
      end
   end

   // Pending slots: fill when free or being drained, else replace or drop.
   always_comb begin
      slot_vld_d  = slot_vld_q;
      slot_kind_d = slot_kind_q;
      dropped_d   = dropped_q;
      for (int i = 0; i < NUM_BTNS; i++) begin
         if (gnt_oh[i]) begin
            slot_vld_d[i] = 1'b0;
         end
         if (emit[i]) begin
            if (!slot_vld_q[i] || gnt_oh[i]) begin
               slot_vld_d[i]  = 1'b1;
               slot_kind_d[i] = emit_kind[i];
            end else begin
               dropped_d = 1'b1;
               if (can_replace(emit_kind[i], slot_kind_q[i])) begin
                  slot_kind_d[i] = emit_kind[i];
               end
            end
         end
      end
   end

   // Event FIFO; a pop in the same cycle never frees room for a grant.
   always_comb begin
      push       = gnt_vld;
      pop        = evt_valid & evt_ready;
      mem_btn_d  = mem_btn_q;
      mem_kind_d = mem_kind_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push) begin
         mem_btn_d[wr_ptr_q]  = gnt_idx;
         mem_kind_d[wr_ptr_q] = slot_kind_q[gnt_idx];
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
      end else if (!push && pop) begin
         fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
      end
   end

   // Head entry and status outputs.
   always_comb begin
      evt_valid   = (fifo_cnt_q != '0);
      evt_btn     = mem_btn_q[rd_ptr_q];
      evt_kind    = mem_kind_q[rd_ptr_q];
      evt_dropped = dropped_q;
   end

   // Registers for slots, arbiter pointer, FIFO and drop flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_vld_q  <= '0;
         slot_kind_q <= '0;
         dropped_q   <= 1'b0;
         rr_ptr_q    <= '0;
         mem_btn_q   <= '0;
         mem_kind_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
      end else begin
         slot_vld_q  <= slot_vld_d;
         slot_kind_q <= slot_kind_d;
         dropped_q   <= dropped_d;
         rr_ptr_q    <= rr_ptr_d;
         mem_btn_q   <= mem_btn_d;
         mem_kind_q  <= mem_kind_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
      end
   end

endmodule
